uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares one uart_transmitter (8N1, start_transmit / tx_busy interface) among N byte-stream requesters.
- Round-robin arbitration per byte, with optional packet lock so one requester keeps the line until it sends its last byte.
- Holds the byte stable for the whole frame, launches each frame with a single start pulse, watches tx_busy for start and end of frame, and inserts a programmable idle gap between frames.
- Sits between the protocol/packet sources and the transmitter.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; equals clog2(N).
- ACK_TIMEOUT, 8, cycles to wait for utx_busy to rise after a launch before re-launching (>=3).
- GAP_CYCLES, 2, idle cycles inserted after utx_busy falls before the next arbitration (0 allowed).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- req_valid  input  N  requester i has a byte
- req_data  input  8*N  byte of requester i at bits [8i+7:8i]
- req_last  input  N  byte of requester i ends its packet
- req_ready  output  N  byte of requester i accepted this cycle (combinational)
- utx_data  output  8  to transmitter data, registered
- utx_start  output  1  to transmitter start_transmit, registered one-cycle pulse
- utx_busy  input  1  from transmitter tx_busy
- grant_id  output  IDW  requester owning the current or last byte
- active  output  1  high from accept until the end of the gap
- lock  output  1  packet lock held
- retry_cnt  output  8  saturating count of launch timeouts

Behaviour:
- Reset values:
  - req_ready=0, utx_data=0x00, utx_start=0, grant_id=N-1 (so requester 0 has top priority), active=0, lock=0, retry_cnt=0.
  - Internal counters = 0, state=IDLE.
  - A reset in any state aborts immediately; the held byte is dropped. The transmitter shares the same reset.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP.
- IDLE:
  - Unlocked: the winner is the first i with req_valid[i]=1, scanning grant_id+1, grant_id+2, ... mod N.
  - Locked: the only candidate is grant_id.
  - req_ready[winner]=1 combinationally in IDLE only; at most one bit is ever set. A transfer is valid&ready.
  - On a transfer:
    - utx_data<=byte, grant_id<=winner, active<=1.
    - lock<=~req_last[winner].
    - Next state LAUNCH.
  - No candidate: stay in IDLE.
- LAUNCH: utx_start=1 for exactly this one cycle, ack counter cleared, next state WAIT_ACK.
- WAIT_ACK:
  - utx_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. When it reaches ACK_TIMEOUT-1: retry_cnt+=1 (saturates at 255), back to LAUNCH with the same byte.
  - The transmitter registers start, so busy normally rises the cycle after utx_start.
- WAIT_DONE: wait for utx_busy=0, then -> GAP (or -> IDLE with active<=0 if GAP_CYCLES=0).
- GAP: count GAP_CYCLES cycles with utx_start=0, then active<=0 -> IDLE.
- Data rules:
  - utx_data changes only on an IDLE transfer, so it is stable from LAUNCH through frame end. The transmitter samples data throughout its start bit.
  - utx_start is never asserted outside LAUNCH. A held start would cause a spurious second frame.
- Lock rules:
  - While locked, other requesters' req_valid are ignored. req_ready for them stays 0 even if the locked requester is idle.
  - lock clears only on an accepted byte with req_last=1. A single-byte packet (last=1 on first byte) never sets lock.
- Round-robin:
  - The pointer is grant_id, updated only on transfer.
  - Simultaneous requests are served in rotating order.
  - Wrap from N-1 to 0 is mandatory.
- utx_busy high while in IDLE (stale) is ignored. utx_busy low during WAIT_DONE on the entry cycle is treated as frame done only after WAIT_ACK has seen it high.
- Throughput:
  - One byte per frame.
  - Accept-to-utx_start latency is 1 cycle.
  - Busy-fall to next req_ready is GAP_CYCLES+1 cycles.

Test Plan:
- After reset, req_valid=4'b0001, byte 0x55, last=1 -> req_ready[0] 1 cycle; utx_start single pulse next cycle; utx_data=0x55 through the frame; transmitter tx shows 0,1,0,1,0,1,0,1,0,1 bit pattern; active drops GAP_CYCLES+1 cycles after busy falls.
- req_valid=4'b1111, all last=1, bytes 0xA0..0xA3 -> frames sent in order 0,1,2,3. Then with 4'b1001 held, order continues 0,3,0,3 (wrap check).
- Requester 2 sends 0x10,0x11,0x12 with last on 0x12 while requesters 0 and 1 are valid throughout -> three consecutive frames from grant_id=2, lock=1 until 0x12 accepted, then requester 0 is served next.
- Tie utx_busy=0 (transmitter disconnected) -> utx_start re-pulses every ACK_TIMEOUT+1 cycles. retry_cnt increments, saturates at 255, and utx_data stays unchanged.
- Assert reset mid-frame (during data bits) with lock=1 -> next cycle all outputs at reset values. The transmitter returns to idle, and after release requester 0 wins first.
- GAP_CYCLES=0 with back-to-back valid on requester 1 -> next req_ready exactly 1 cycle after utx_busy falls; utx_start never high for 2 consecutive cycles.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler sharing one 8N1 UART transmitter among N requesters,
// with optional packet lock, launch retry on missing busy, and a post-frame idle gap.
module uart_tx_scheduler #(
  parameter int unsigned N           = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic [7:0]       utx_data,
  output logic             utx_start,
  input  logic             utx_busy,
  output logic [IDW-1:0]   grant_id,
  output logic             active,
  output logic             lock,
  output logic [7:0]       retry_cnt
);

  localparam int unsigned AckW = $clog2(ACK_TIMEOUT);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitAck,
    StWaitDone,
    StGap
  } state_e;

  state_e          state_q;
  logic [7:0]      utx_data_q;
  logic            utx_start_q;
  logic [IDW-1:0]  grant_id_q;
  logic            active_q;
  logic            lock_q;
  logic [7:0]      retry_cnt_q;
  logic [AckW-1:0] ack_cnt_q;
  logic [GapW-1:0] gap_cnt_q;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [7:0]      win_data;

  // Scan from grant_id+N down to grant_id+1 so the nearest successor is written last.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = grant_id_q;
    if (lock_q) begin
      win_found = req_valid[grant_id_q];
    end else begin
      for (int unsigned k = N; k >= 1; k--) begin
        idx = (32'(grant_id_q) + k) % N;
        if (req_valid[idx[IDW-1:0]]) begin
          win_found = 1'b1;
          win_id    = idx[IDW-1:0];
        end
      end
    end
  end

  assign win_data = req_data[{win_id, 3'b000} +: 8];

  always_comb begin
    req_ready = '0;
    if (!reset && state_q == StIdle && win_found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      utx_data_q  <= 8'h00;
      utx_start_q <= 1'b0;
      grant_id_q  <= IDW'(N - 1);
      active_q    <= 1'b0;
      lock_q      <= 1'b0;
      retry_cnt_q <= 8'h00;
      ack_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      utx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            utx_data_q  <= win_data;
            grant_id_q  <= win_id;
            active_q    <= 1'b1;
            lock_q      <= ~req_last[win_id];
            utx_start_q <= 1'b1;
            state_q     <= StLaunch;
          end
        end
        StLaunch: begin
          ack_cnt_q <= '0;
          state_q   <= StWaitAck;
        end
        StWaitAck: begin
          if (utx_busy) begin
            state_q <= StWaitDone;
          end else if (ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
            if (retry_cnt_q != 8'hFF) begin
              retry_cnt_q <= retry_cnt_q + 8'd1;
            end
            utx_start_q <= 1'b1;
            state_q     <= StLaunch;
          end else begin
            ack_cnt_q <= ack_cnt_q + AckW'(1);
          end
        end
        StWaitDone: begin
          if (!utx_busy) begin
            if (GAP_CYCLES == 0) begin
              active_q <= 1'b0;
              state_q  <= StIdle;
            end else begin
              gap_cnt_q <= '0;
              state_q   <= StGap;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
            active_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign utx_data  = utx_data_q;
  assign utx_start = utx_start_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;
  assign lock      = lock_q;
  assign retry_cnt = retry_cnt_q;

endmodule
